wrr_rank_calc: RTL and testbench
================================

Name: wrr_rank_calc

Overview:
- Weighted-round-robin rank calculator feeding the PIFO scheduler.
- Each data-path packet descriptor {port one-hot, class} is mapped to a flow (port, class).
- The block returns a rank = {virtual round, class} and updates that flow's round and packet counter.
- A CPU port writes per-flow weights and reads back per-flow state; all state lives in flip-flops (no block RAM).

Parameters:
- NUM_PORTS, 5, ports supported; one last_pkt_info input each.
- NUM_CLASSES, 4, classes per port.
- DEFAULT_WEIGHT, 1, weight loaded at reset.

Ports:
- clk_dp  in  1  single clock for data path and CPU path.
- rst  in  1  asynchronous, active-low reset.
- tuple_in_my_pifo_rank_calc_input_VALID  in  1  descriptor strobe.
- tuple_in_my_pifo_rank_calc_input_DATA  in  13  [12:5] port one-hot, [4:0] class id.
- tuple_out_my_pifo_rank_calc_output_VALID  out  1  result strobe.
- tuple_out_my_pifo_rank_calc_output_DATA  out  32  {valid 1, rank 19, pifo_info 12}.
- wire_in_last_pkt_info0..4  in  32 each  per-port last dequeued {valid[31], rank[30:12], info[11:0]}.
- wire_in_cpu_valid  in  1  CPU request strobe.
- wire_in_cpu_index  in  8  [7:5] port index, [4:0] class.
- wire_in_cpu_write_sig  in  1  write request.
- wire_in_cpu_config_write  in  9  [7:0] weight; [8] also clears that flow's round and counter.
- wire_in_cpu_read_sig  in  1  read request.
- wire_out_cpu_index  out  8  echoed index.
- wire_out_cpu_val  out  27  {round[26:16], weight[15:8], counter[7:0]}.
- wire_out_cpu_valid  out  1  read-response strobe.

Behaviour:
- Reset (rst=0, async): every round=0, counter=0, weight=DEFAULT_WEIGHT; all outputs 0.
- Flow state per (port, class): round 11b, weight 8b, counter 8b.
- Port index: lowest set bit of the port one-hot; class uses the low bits of the class id.
- cur_round[p] = info_p[30:20] when info_p[31]=1, else 0.
- Data path, per accepted descriptor:
  - weight of 0 is treated as 1.
  - base = max(round, cur_round[p]).
  - rank = {base[10:0], 3'b0, class[4:0]}.
  - If counter+1 >= weight: counter←0, round←base+1 (11-bit wrap); else counter←counter+1, round←base.
- Output timing: registered, 1-cycle latency. Output DATA = {1, rank, port_onehot[7:0], class[3:0]}; DATA is 0 whenever VALID is 0.
- Back-to-back descriptors to the same flow see the previous update; full rate, no stall.
- Invalid descriptor (port one-hot = 0, port index >= NUM_PORTS, or class >= NUM_CLASSES): output VALID=1, rank = all ones, no state change.
- CPU write (valid & write_sig): weight←config[7:0] at the next edge; if config[8]=1, round and counter are also cleared. No response strobe.
- CPU read (valid & read_sig): one cycle later wire_out_cpu_valid=1 with the index echoed and the flow state.
  - Read and write in the same cycle: the read returns the post-write value.
- Out-of-range CPU index: write ignored; read returns val=0 with valid=1.
- Same-cycle CPU write and DP update to the same flow: weight comes from the CPU; round and counter come from the DP computation, unless config[8]=1, in which case the clear wins.

Optional Feature:
- WRR_ROUND_SAT_EN defined: round saturates at 2047 instead of wrapping to 0.
- Undefined: 11-bit wrap.

Decomposition:
- Package wrr_pkg: width constants (ROUND_W=11, WEIGHT_W=8, CNT_W=8, RANK_W=19, INFO_W=12), a flow-state struct typedef, and the INVALID_RANK constant.
- One combinational sub-module, wrr_flow_update: takes {round, weight, counter, cur_round}, returns {rank_round, next_round, next_counter}.

Test Plan:
- Reset, then CPU read of port0/class2 -> val={0, 1, 0}, valid one cycle later.
- Write weights 5,3,2,1 to port0 classes 0..3; read each -> weights 5,3,2,1, round 0, counter 0.
- Ten port0/class0 descriptors (one-hot 0x01) with info0=0 -> ranks 0x000 ×5, then 0x100 ×5; final read: round 2, counter 0.
- Set info0=0x88000000 (cur_round 128); send port0/class0 -> rank 0x8000.
- Send port0/class2 with weight 2 after two prior packets (round 1) -> rank 0x8002, since cur_round 128 dominates.
- Port one-hot 0x00 or class 7 -> rank 0x7FFFF with valid=1; CPU read confirms no state change.
- Assert rst mid-stream -> outputs 0 immediately; subsequent read returns weight 1.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared widths, per-flow state record and small helpers for the WRR rank calculator.
package wrr_pkg;

  localparam int ROUND_W  = 11;
  localparam int WEIGHT_W = 8;
  localparam int CNT_W    = 8;
  localparam int RANK_W   = 19;
  localparam int INFO_W   = 12;

  localparam logic [RANK_W-1:0] INVALID_RANK = '1;

  // Field order matches the CPU read-back word {round, weight, counter}.
  typedef struct packed {
    logic [ROUND_W-1:0]  round;
    logic [WEIGHT_W-1:0] weight;
    logic [CNT_W-1:0]    counter;
  } flow_state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] onehot);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/wrr_flow_update.sv
// Combinational per-packet WRR update for one flow.
// Define WRR_ROUND_SAT_EN to saturate the round at its maximum instead of wrapping.
module wrr_flow_update
  import wrr_pkg::*;
(
  input  logic [ROUND_W-1:0]  round,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [CNT_W-1:0]    counter,
  input  logic [ROUND_W-1:0]  cur_round,
  output logic [ROUND_W-1:0]  rank_round,
  output logic [ROUND_W-1:0]  next_round,
  output logic [CNT_W-1:0]    next_counter
);

  logic [WEIGHT_W-1:0] eff_weight;
  logic [CNT_W:0]      cnt_inc;
  logic [ROUND_W-1:0]  base;

  // A flow never ranks behind the round currently being dequeued on its port.
  always_comb begin
    eff_weight   = (weight == '0) ? WEIGHT_W'(1) : weight;
    base         = (round > cur_round) ? round : cur_round;
    cnt_inc      = {1'b0, counter} + (CNT_W+1)'(1);
    rank_round   = base;
    next_round   = base;
    next_counter = cnt_inc[CNT_W-1:0];
    if (cnt_inc >= {1'b0, eff_weight}) begin
      next_counter = '0;
`ifdef WRR_ROUND_SAT_EN
      next_round   = (&base) ? base : base + ROUND_W'(1);
`else
      next_round   = base + ROUND_W'(1);
`endif
    end
  end

endmodule

// File: rtl/wrr_rank_calc.sv
// Weighted-round-robin rank calculator: maps descriptors to per-flow ranks for the PIFO,
// with a CPU port for per-flow weight writes and state read-back.
module wrr_rank_calc
  import wrr_pkg::*;
#(
  parameter int NUM_PORTS      = 5,
  parameter int NUM_CLASSES    = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic        clk_dp,
  input  logic        rst,
  input  logic        tuple_in_my_pifo_rank_calc_input_VALID,
  input  logic [12:0] tuple_in_my_pifo_rank_calc_input_DATA,
  output logic        tuple_out_my_pifo_rank_calc_output_VALID,
  output logic [31:0] tuple_out_my_pifo_rank_calc_output_DATA,
  input  logic [31:0] wire_in_last_pkt_info0,
  input  logic [31:0] wire_in_last_pkt_info1,
  input  logic [31:0] wire_in_last_pkt_info2,
  input  logic [31:0] wire_in_last_pkt_info3,
  input  logic [31:0] wire_in_last_pkt_info4,
  input  logic        wire_in_cpu_valid,
  input  logic [7:0]  wire_in_cpu_index,
  input  logic        wire_in_cpu_write_sig,
  input  logic [8:0]  wire_in_cpu_config_write,
  input  logic        wire_in_cpu_read_sig,
  output logic [7:0]  wire_out_cpu_index,
  output logic [26:0] wire_out_cpu_val,
  output logic        wire_out_cpu_valid
);

  localparam int NUM_FLOWS = NUM_PORTS * NUM_CLASSES;
  localparam int FLOW_IW   = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

  flow_state_t flows     [NUM_FLOWS];
  flow_state_t flows_nxt [NUM_FLOWS];

  logic [7:0]         dp_onehot;
  logic [4:0]         dp_class_id;
  logic [2:0]         dp_port;
  logic               dp_ok;
  logic               dp_fire;
  logic [FLOW_IW-1:0] dp_flow;
  flow_state_t        dp_state;
  logic [31:0]        dp_info;
  logic [ROUND_W-1:0] cur_round;
  logic [ROUND_W-1:0] rank_round;
  logic [ROUND_W-1:0] next_round;
  logic [CNT_W-1:0]   next_counter;
  logic [RANK_W-1:0]  dp_rank;
  logic               unused_info;

  logic [2:0]         cpu_port;
  logic [4:0]         cpu_class;
  logic               cpu_ok;
  logic               cpu_wr;
  logic               cpu_rd;
  logic [FLOW_IW-1:0] cpu_flow;

  assign dp_onehot   = tuple_in_my_pifo_rank_calc_input_DATA[12:5];
  assign dp_class_id = tuple_in_my_pifo_rank_calc_input_DATA[4:0];
  assign dp_port     = lowest_set(dp_onehot);
  assign dp_ok       = (dp_onehot != '0) && (int'(dp_port) < NUM_PORTS)
                       && (int'(dp_class_id) < NUM_CLASSES);
  assign dp_fire     = tuple_in_my_pifo_rank_calc_input_VALID && dp_ok;
  assign dp_flow     = dp_ok ? FLOW_IW'(int'(dp_port) * NUM_CLASSES + int'(dp_class_id)) : '0;
  assign dp_state    = flows[dp_flow];

  always_comb begin
    dp_info = '0;
    case (dp_port)
      3'd0:    dp_info = wire_in_last_pkt_info0;
      3'd1:    dp_info = wire_in_last_pkt_info1;
      3'd2:    dp_info = wire_in_last_pkt_info2;
      3'd3:    dp_info = wire_in_last_pkt_info3;
      3'd4:    dp_info = wire_in_last_pkt_info4;
      default: dp_info = '0;
    endcase
    cur_round = dp_info[31] ? dp_info[30:20] : '0;
  end

  assign unused_info = ^dp_info[19:0];

  wrr_flow_update u_flow_update (
    .round        (dp_state.round),
    .weight       (dp_state.weight),
    .counter      (dp_state.counter),
    .cur_round    (cur_round),
    .rank_round   (rank_round),
    .next_round   (next_round),
    .next_counter (next_counter)
  );

  assign dp_rank = dp_ok ? {rank_round, 3'b000, dp_class_id} : INVALID_RANK;

  assign cpu_port  = wire_in_cpu_index[7:5];
  assign cpu_class = wire_in_cpu_index[4:0];
  assign cpu_ok    = (int'(cpu_port) < NUM_PORTS) && (int'(cpu_class) < NUM_CLASSES);
  assign cpu_wr    = wire_in_cpu_valid && wire_in_cpu_write_sig && cpu_ok;
  assign cpu_rd    = wire_in_cpu_valid && wire_in_cpu_read_sig;
  assign cpu_flow  = cpu_ok ? FLOW_IW'(int'(cpu_port) * NUM_CLASSES + int'(cpu_class)) : '0;

  // CPU write is applied after the data-path update so its weight and optional clear win.
  always_comb begin
    for (int i = 0; i < NUM_FLOWS; i++) flows_nxt[i] = flows[i];
    if (dp_fire) begin
      flows_nxt[dp_flow].round   = next_round;
      flows_nxt[dp_flow].counter = next_counter;
    end
    if (cpu_wr) begin
      flows_nxt[cpu_flow].weight = wire_in_cpu_config_write[7:0];
      if (wire_in_cpu_config_write[8]) begin
        flows_nxt[cpu_flow].round   = '0;
        flows_nxt[cpu_flow].counter = '0;
      end
    end
  end

  // Read-back samples the next-state array so a same-cycle write is already visible.
  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        flows[i] <= '{round: '0, weight: WEIGHT_W'(DEFAULT_WEIGHT), counter: '0};
      end
      tuple_out_my_pifo_rank_calc_output_VALID <= 1'b0;
      tuple_out_my_pifo_rank_calc_output_DATA  <= '0;
      wire_out_cpu_valid                       <= 1'b0;
      wire_out_cpu_index                       <= '0;
      wire_out_cpu_val                         <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) flows[i] <= flows_nxt[i];
      tuple_out_my_pifo_rank_calc_output_VALID <= tuple_in_my_pifo_rank_calc_input_VALID;
      tuple_out_my_pifo_rank_calc_output_DATA  <= tuple_in_my_pifo_rank_calc_input_VALID ?
          {1'b1, dp_rank, dp_onehot, dp_class_id[3:0]} : '0;
      wire_out_cpu_valid <= cpu_rd;
      wire_out_cpu_index <= cpu_rd ? wire_in_cpu_index : '0;
      wire_out_cpu_val   <= (cpu_rd && cpu_ok) ? flows_nxt[cpu_flow] : '0;
    end
  end

endmodule

// File: tb/tb_wrr_rank_calc.sv
// Self-checking bench for wrr_rank_calc: table-driven descriptors and CPU reads feed
// expectation queues that a negedge monitor checks against the DUT outputs.
module tb_wrr_rank_calc;

  logic        clk_dp = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] info0, info1, info2, info3, info4;
  logic        cpu_valid;
  logic [7:0]  cpu_index;
  logic        cpu_write_sig;
  logic [8:0]  cpu_config;
  logic        cpu_read_sig;
  logic [7:0]  cpu_out_index;
  logic [26:0] cpu_out_val;
  logic        cpu_out_valid;

  always #5 clk_dp = ~clk_dp;

  wrr_rank_calc dut (
    .clk_dp                                   (clk_dp),
    .rst                                      (rst),
    .tuple_in_my_pifo_rank_calc_input_VALID   (in_valid),
    .tuple_in_my_pifo_rank_calc_input_DATA    (in_data),
    .tuple_out_my_pifo_rank_calc_output_VALID (out_valid),
    .tuple_out_my_pifo_rank_calc_output_DATA  (out_data),
    .wire_in_last_pkt_info0                   (info0),
    .wire_in_last_pkt_info1                   (info1),
    .wire_in_last_pkt_info2                   (info2),
    .wire_in_last_pkt_info3                   (info3),
    .wire_in_last_pkt_info4                   (info4),
    .wire_in_cpu_valid                        (cpu_valid),
    .wire_in_cpu_index                        (cpu_index),
    .wire_in_cpu_write_sig                    (cpu_write_sig),
    .wire_in_cpu_config_write                 (cpu_config),
    .wire_in_cpu_read_sig                     (cpu_read_sig),
    .wire_out_cpu_index                       (cpu_out_index),
    .wire_out_cpu_val                         (cpu_out_val),
    .wire_out_cpu_valid                       (cpu_out_valid)
  );

  typedef struct {
    logic [12:0] din;
    logic [31:0] info0;
    logic [31:0] info3;
    logic [18:0] rank;
  } dp_vec_t;

  typedef struct {
    logic [7:0]  idx;
    logic [26:0] val;
  } rd_vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } dp_exp_t;

  typedef struct {
    logic [7:0]  idx;
    logic [26:0] val;
    int          due;
  } cpu_exp_t;

`ifdef WRR_ROUND_SAT_EN
  localparam logic [18:0] P3_SECOND_RANK = 19'h7FF00;
  localparam logic [26:0] P3_STATE       = 27'h7FF0100;
`else
  localparam logic [18:0] P3_SECOND_RANK = 19'h00000;
  localparam logic [26:0] P3_STATE       = 27'h0010100;
`endif

  dp_exp_t  dp_q[$];
  cpu_exp_t cpu_q[$];
  dp_vec_t  dp_vecs[$];
  rd_vec_t  rd_vecs[$];
  dp_exp_t  dp_e;
  cpu_exp_t cpu_e;
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;

  function automatic logic [31:0] mk_out(input logic [18:0] rank, input logic [12:0] din);
    mk_out = {1'b1, rank, din[12:5], din[3:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dp_v, input logic [12:0] dp_d,
                               input logic [31:0] dp_exp, input logic c_v,
                               input logic [7:0] idx, input logic wr,
                               input logic [8:0] cfg, input logic rd,
                               input logic [26:0] c_exp);
    in_valid      = dp_v;
    in_data       = dp_d;
    cpu_valid     = c_v;
    cpu_index     = idx;
    cpu_write_sig = wr;
    cpu_config    = cfg;
    cpu_read_sig  = rd;
    if (dp_v) dp_q.push_back('{data: dp_exp, due: cyc + 1});
    if (c_v && rd) cpu_q.push_back('{idx: idx, val: c_exp, due: cyc + 1});
    @(posedge clk_dp);
    #1;
    in_valid      = 1'b0;
    in_data       = '0;
    cpu_valid     = 1'b0;
    cpu_index     = '0;
    cpu_write_sig = 1'b0;
    cpu_config    = '0;
    cpu_read_sig  = 1'b0;
  endtask

  task automatic send_dp(input logic [12:0] din, input logic [18:0] rank);
    applyStimulus(1'b1, din, mk_out(rank, din), 1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 27'h0);
  endtask

  task automatic cpu_write(input logic [7:0] idx, input logic [8:0] cfg);
    applyStimulus(1'b0, 13'h0, 32'h0, 1'b1, idx, 1'b1, cfg, 1'b0, 27'h0);
  endtask

  task automatic cpu_read(input logic [7:0] idx, input logic [26:0] val);
    applyStimulus(1'b0, 13'h0, 32'h0, 1'b1, idx, 1'b0, 9'h000, 1'b1, val);
  endtask

  always @(posedge clk_dp) cyc++;

  // Every negedge either consumes a due expectation or requires the outputs to be idle.
  always @(negedge clk_dp) begin
    if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
      dp_e = dp_q.pop_front();
      checkOutput("dp_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("dp_data", out_data, dp_e.data);
    end else begin
      checkOutput("dp_idle_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("dp_idle_data", out_data, 32'd0);
    end
    if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
      cpu_e = cpu_q.pop_front();
      checkOutput("cpu_valid", {31'b0, cpu_out_valid}, 32'd1);
      checkOutput("cpu_index", {24'b0, cpu_out_index}, {24'b0, cpu_e.idx});
      checkOutput("cpu_val", {5'b0, cpu_out_val}, {5'b0, cpu_e.val});
    end else begin
      checkOutput("cpu_idle_valid", {31'b0, cpu_out_valid}, 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) dp_vecs.push_back('{13'h020, 32'h0, 32'h0, 19'h00000});
    for (int i = 0; i < 5; i++) dp_vecs.push_back('{13'h020, 32'h0, 32'h0, 19'h00100});
    dp_vecs.push_back('{13'h022, 32'h0,        32'h0,        19'h00002});
    dp_vecs.push_back('{13'h022, 32'h0,        32'h0,        19'h00002});
    dp_vecs.push_back('{13'h020, 32'h88000000, 32'h0,        19'h08000});
    dp_vecs.push_back('{13'h022, 32'h88000000, 32'h0,        19'h08002});
    dp_vecs.push_back('{13'h000, 32'h88000000, 32'h0,        19'h7FFFF});
    dp_vecs.push_back('{13'h027, 32'h88000000, 32'h0,        19'h7FFFF});
    dp_vecs.push_back('{13'h024, 32'h88000000, 32'h0,        19'h7FFFF});
    dp_vecs.push_back('{13'h400, 32'h88000000, 32'h0,        19'h7FFFF});
    dp_vecs.push_back('{13'h440, 32'h88000000, 32'h0,        19'h00000});
    dp_vecs.push_back('{13'h040, 32'h88000000, 32'h0,        19'h00100});
    dp_vecs.push_back('{13'h203, 32'h88000000, 32'h0,        19'h00003});
    dp_vecs.push_back('{13'h100, 32'h88000000, 32'hFFF00000, 19'h7FF00});
    dp_vecs.push_back('{13'h100, 32'h88000000, 32'h0,        P3_SECOND_RANK});

    rd_vecs.push_back('{8'h00, 27'h0800501});
    rd_vecs.push_back('{8'h02, 27'h0800201});
    rd_vecs.push_back('{8'h03, 27'h0000100});
    rd_vecs.push_back('{8'h20, 27'h0020100});
    rd_vecs.push_back('{8'h60, P3_STATE});
    rd_vecs.push_back('{8'h83, 27'h0010100});

    rst = 1'b0;
    {in_valid, in_data, cpu_valid, cpu_index, cpu_write_sig, cpu_config, cpu_read_sig} = '0;
    {info0, info1, info2, info3, info4} = '0;
    repeat (2) @(posedge clk_dp);
    #1;
    checkOutput("rst_dp_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_dp_data", out_data, 32'd0);
    checkOutput("rst_cpu_valid", {31'b0, cpu_out_valid}, 32'd0);
    checkOutput("rst_cpu_index", {24'b0, cpu_out_index}, 32'd0);
    checkOutput("rst_cpu_val", {5'b0, cpu_out_val}, 32'd0);
    rst = 1'b1;

    $display("[TB] reset read-back and weight programming");
    cpu_read(8'h02, 27'h0000100);
    cpu_write(8'h00, 9'd5);
    cpu_write(8'h01, 9'd3);
    cpu_write(8'h02, 9'd2);
    cpu_write(8'h03, 9'd1);
    cpu_read(8'h00, 27'h0000500);
    cpu_read(8'h01, 27'h0000300);
    cpu_read(8'h02, 27'h0000200);
    cpu_read(8'h03, 27'h0000100);

    $display("[TB] descriptor table");
    for (int i = 0; i < dp_vecs.size(); i++) begin
      info0 = dp_vecs[i].info0;
      info3 = dp_vecs[i].info3;
      send_dp(dp_vecs[i].din, dp_vecs[i].rank);
    end
    for (int i = 0; i < rd_vecs.size(); i++) cpu_read(rd_vecs[i].idx, rd_vecs[i].val);

    $display("[TB] zero weight, clear, and same-cycle corner cases");
    cpu_write(8'h41, 9'h000);
    send_dp(13'h081, 19'h00001);
    send_dp(13'h081, 19'h00101);
    cpu_read(8'h41, 27'h0020000);
    cpu_write(8'h00, 9'h103);
    cpu_read(8'h00, 27'h0000300);
    applyStimulus(1'b0, 13'h0, 32'h0, 1'b1, 8'h01, 1'b1, 9'h007, 1'b1, 27'h0000700);
    info0 = 32'h88000000;
    applyStimulus(1'b1, 13'h021, mk_out(19'h08001, 13'h021), 1'b1, 8'h01, 1'b1, 9'h004,
                  1'b0, 27'h0);
    cpu_read(8'h01, 27'h0800401);
    applyStimulus(1'b1, 13'h021, mk_out(19'h08001, 13'h021), 1'b1, 8'h01, 1'b1, 9'h104,
                  1'b0, 27'h0);
    cpu_read(8'h01, 27'h0000400);

    $display("[TB] out-of-range CPU indices");
    cpu_write(8'hA0, 9'h1FF);
    cpu_write(8'h04, 9'h109);
    cpu_read(8'hA0, 27'h0);
    cpu_read(8'h04, 27'h0);
    cpu_read(8'hE0, 27'h0);
    cpu_read(8'h20, 27'h0020100);
    cpu_read(8'h00, 27'h0000300);

    $display("[TB] reset asserted mid-stream");
    in_valid     = 1'b1;
    in_data      = 13'h020;
    cpu_valid    = 1'b1;
    cpu_index    = 8'h00;
    cpu_read_sig = 1'b1;
    @(posedge clk_dp);
    #1;
    checkOutput("pre_rst_dp_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pre_rst_dp_data", out_data, mk_out(19'h08000, 13'h020));
    checkOutput("pre_rst_cpu_val", {5'b0, cpu_out_val}, 32'h0800301);
    {in_valid, in_data, cpu_valid, cpu_index, cpu_read_sig} = '0;
    rst = 1'b0;
    #1;
    checkOutput("midrst_dp_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_dp_data", out_data, 32'd0);
    checkOutput("midrst_cpu_valid", {31'b0, cpu_out_valid}, 32'd0);
    checkOutput("midrst_cpu_val", {5'b0, cpu_out_val}, 32'd0);
    repeat (2) @(posedge clk_dp);
    #1;
    rst = 1'b1;
    cpu_read(8'h00, 27'h0000100);
    cpu_read(8'h01, 27'h0000100);
    cpu_read(8'h41, 27'h0000100);

    repeat (3) @(posedge clk_dp);
    #1;
    checkOutput("dp_q_drained", 32'(dp_q.size()), 32'd0);
    checkOutput("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
